// File: rtl/nv_nvdla_cdma_wt_pkg.sv
// Shared constants and state encoding for the CDMA weight/feature fetch
// request generators.
package nv_nvdla_cdma_wt_pkg;

    localparam int ATOM_SHIFT    = 5;
    localparam int MAX_REQ_ATOMS = 64;
    localparam int PAGE_ATOMS    = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } wt_state_e;

endpackage

// File: rtl/nv_nvdla_cdma_wt_req_gen_if.sv
// DMA read-request channel plus weight tracking FIFO push port, bundled as
// seen from the request generator (master) and its consumers (slave).
interface nv_nvdla_cdma_wt_req_gen_if #(
    parameter int ADDR_W = 64
);
    logic              dma_rd_req_valid;
    logic              dma_rd_req_ready;
    logic [ADDR_W-1:0] dma_rd_req_addr;
    logic [5:0]        dma_rd_req_size;
    logic              wr_req;
    logic              wr_ready;
    logic [5:0]        wr_data;

    modport master (
        output dma_rd_req_valid, dma_rd_req_addr, dma_rd_req_size, wr_req, wr_data,
        input  dma_rd_req_ready, wr_ready
    );

    modport slave (
        input  dma_rd_req_valid, dma_rd_req_addr, dma_rd_req_size, wr_req, wr_data,
        output dma_rd_req_ready, wr_ready
    );

endinterface

// File: rtl/nv_nvdla_cdma_wt_req_size.sv
// Request sizing: the largest chunk that fits the remaining atoms, the
// per-request cap and the rest of the current 4 KB page.
module nv_nvdla_cdma_wt_req_size
    import nv_nvdla_cdma_wt_pkg::*;
#(
    parameter int LEN_W = 24
) (
    input  logic [LEN_W-1:0] remaining,
    input  logic [6:0]       page_off,
    output logic [7:0]       req_atoms,
    output logic [5:0]       req_size
);

    logic [7:0] page_left;
    logic [7:0] cap;

    // page_left spans 1..128; the size encode is only meaningful when remaining != 0
    always_comb begin
        page_left = 8'(PAGE_ATOMS) - {1'b0, page_off};
        cap       = (page_left < 8'(MAX_REQ_ATOMS)) ? page_left : 8'(MAX_REQ_ATOMS);
        if (remaining < LEN_W'(cap)) begin
            req_atoms = remaining[7:0];
        end else begin
            req_atoms = cap;
        end
        req_size = 6'(req_atoms - 8'd1);
    end

endmodule

// File: rtl/nv_nvdla_cdma_wt_req_gen.sv
// Weight-fetch request generator: splits one job into page-safe DMA reads
// and pushes each request's size into the weight tracking FIFO.
module nv_nvdla_cdma_wt_req_gen
    import nv_nvdla_cdma_wt_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ADDR_W-1:0]           cfg_addr,
    input  logic [LEN_W-1:0]            cfg_atoms,
    nv_nvdla_cdma_wt_req_gen_if.master  dma,
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 stall_cnt
);

    wt_state_e         state;
    wt_state_e         next_state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic [7:0]        req_atoms;
    logic [5:0]        req_size;
    logic              accept;
    logic              fire;
    logic              last_req;

    nv_nvdla_cdma_wt_req_size #(.LEN_W(LEN_W)) u_req_size (
        .remaining (remaining),
        .page_off  (cur_addr[11:5]),
        .req_atoms (req_atoms),
        .req_size  (req_size)
    );

    assign accept   = cfg_valid && (state == IDLE);
    assign fire     = dma.dma_rd_req_valid && dma.dma_rd_req_ready;
    assign last_req = (remaining == LEN_W'(req_atoms));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (cfg_atoms == '0) ? DONE : ISSUE;
            ISSUE:   if (fire && last_req) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Valid follows wr_ready so a request is never issued without a FIFO slot for it
    always_comb begin
        cfg_ready            = (state == IDLE);
        busy                 = (state != IDLE);
        done                 = (state == DONE);
        dma.dma_rd_req_valid = (state == ISSUE) && dma.wr_ready;
        dma.dma_rd_req_addr  = cur_addr;
        dma.dma_rd_req_size  = req_size;
        dma.wr_req           = fire;
        dma.wr_data          = req_size;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (accept) begin
            cur_addr  <= cfg_addr & ~ADDR_W'((1 << ATOM_SHIFT) - 1);
            remaining <= cfg_atoms;
        end else if (fire) begin
            cur_addr  <= cur_addr + (ADDR_W'(req_atoms) << ATOM_SHIFT);
            remaining <= remaining - LEN_W'(req_atoms);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (dma.dma_rd_req_valid && !dma.dma_rd_req_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
